// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, aligns load data,
// forwards to WB. Optional macro MS_LOAD_BYPASS_EN exposes load data to ID in the data_ok cycle.
module mem_stage #(
    parameter int EXC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             es_to_ms_valid,
    output logic             ms_allowin,
    input  logic [31:0]      es_pc,
    input  logic [31:0]      es_result,
    input  logic             es_rf_we,
    input  logic [4:0]       es_rf_waddr,
    input  logic             es_res_from_mem,
    input  logic             es_mem_req,
    input  logic [4:0]       es_ld_op,
    input  logic [EXC_W-1:0] es_except,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    input  logic             ws_allowin,
    input  logic             except_flush,
    output logic             ms_to_ws_valid,
    output logic [31:0]      ms_pc,
    output logic [31:0]      ms_final_result,
    output logic             ms_rf_we,
    output logic [4:0]       ms_rf_waddr,
    output logic [EXC_W-1:0] ms_except,
    output logic [38:0]      ms_rf_collect
);

    logic             ms_valid_reg;
    logic [31:0]      ms_pc_reg;
    logic [31:0]      ms_result_reg;
    logic             ms_rf_we_reg;
    logic [4:0]       ms_rf_waddr_reg;
    logic             ms_res_from_mem_reg;
    logic             ms_mem_req_reg;
    logic [4:0]       ms_ld_op_reg;
    logic [EXC_W-1:0] ms_except_reg;
    logic [31:0]      data_buf_reg;
    logic             data_buf_valid_reg;
    logic [1:0]       discard_cnt_reg;

    logic        ms_wait;
    logic        resp_ok;
    logic        resp_drop;
    logic        resp_orphan;
    logic        ms_ready_go;
    logic        ms_leave;
    logic        ms_load_pending;
    logic [31:0] load_src;
    logic [31:0] bypass_result;

    // ld_op bit order is {ld_w, ld_h, ld_hu, ld_b, ld_bu}
    function automatic logic [31:0] load_align(input logic [4:0] op, input logic [1:0] off,
                                               input logic [31:0] src);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = src[7:0];
            2'd1:    b = src[15:8];
            2'd2:    b = src[23:16];
            default: b = src[31:24];
        endcase
        h = off[1] ? src[31:16] : src[15:0];
        r = 32'd0;
        if (op[4]) r = src;
        if (op[3]) r = {{16{h[15]}}, h};
        if (op[2]) r = {16'd0, h};
        if (op[1]) r = {{24{b[7]}}, b};
        if (op[0]) r = {24'd0, b};
        return r;
    endfunction

    assign ms_wait     = ms_valid_reg & ms_mem_req_reg & ~data_buf_valid_reg;
    assign resp_ok     = data_sram_data_ok & (discard_cnt_reg == 2'd0);
    assign resp_drop   = data_sram_data_ok & (discard_cnt_reg != 2'd0);
    // A flushed instruction whose response has not arrived leaves one response in flight.
    assign resp_orphan = except_flush & ms_wait & ~resp_ok;
    assign ms_ready_go = ~ms_wait | resp_ok;
    assign ms_leave    = ms_ready_go & ws_allowin;
    assign ms_allowin  = ~ms_valid_reg | ms_leave;

    assign ms_to_ws_valid = ms_valid_reg & ms_ready_go & ~except_flush;

    assign load_src        = data_buf_valid_reg ? data_buf_reg : data_sram_rdata;
    assign ms_final_result = ms_res_from_mem_reg
                           ? load_align(ms_ld_op_reg, ms_result_reg[1:0], load_src)
                           : ms_result_reg;

    assign ms_pc       = ms_pc_reg;
    assign ms_rf_we    = ms_valid_reg & ms_rf_we_reg;
    assign ms_rf_waddr = ms_valid_reg ? ms_rf_waddr_reg : 5'd0;
    assign ms_except   = ms_valid_reg ? ms_except_reg : '0;

`ifdef MS_LOAD_BYPASS_EN
    assign ms_load_pending = ms_valid_reg & ms_res_from_mem_reg & ~ms_ready_go;
    assign bypass_result   = ms_final_result;
`else
    // ID only sees load data once it sits in data_buf, one cycle after data_ok.
    assign ms_load_pending = ms_valid_reg & ms_res_from_mem_reg & ms_wait;
    assign bypass_result   = ms_res_from_mem_reg
                           ? load_align(ms_ld_op_reg, ms_result_reg[1:0], data_buf_reg)
                           : ms_result_reg;
`endif

    assign ms_rf_collect = {ms_load_pending, ms_rf_we, ms_rf_waddr, bypass_result};

    always_ff @(posedge clk) begin
        if (reset || except_flush) begin
            ms_valid_reg <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_reg <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_pc_reg           <= 32'd0;
            ms_result_reg       <= 32'd0;
            ms_rf_we_reg        <= 1'b0;
            ms_rf_waddr_reg     <= 5'd0;
            ms_res_from_mem_reg <= 1'b0;
            ms_mem_req_reg      <= 1'b0;
            ms_ld_op_reg        <= 5'd0;
            ms_except_reg       <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            ms_pc_reg           <= es_pc;
            ms_result_reg       <= es_result;
            ms_rf_we_reg        <= es_rf_we;
            ms_rf_waddr_reg     <= es_rf_waddr;
            ms_res_from_mem_reg <= es_res_from_mem;
            ms_mem_req_reg      <= es_mem_req;
            ms_ld_op_reg        <= es_ld_op;
            ms_except_reg       <= es_except;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || except_flush || ms_leave) begin
            data_buf_valid_reg <= 1'b0;
        end else if (resp_ok && ms_wait) begin
            data_buf_valid_reg <= 1'b1;
        end
        if (reset) begin
            data_buf_reg <= 32'd0;
        end else if (resp_ok && ms_wait && !ms_leave) begin
            data_buf_reg <= data_sram_rdata;
        end
    end

    // Orphan and drop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt_reg <= 2'd0;
        end else if (resp_orphan && !resp_drop) begin
            if (discard_cnt_reg != 2'd3) discard_cnt_reg <= discard_cnt_reg + 2'd1;
        end else if (resp_drop && !resp_orphan) begin
            discard_cnt_reg <= discard_cnt_reg - 2'd1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized loads/ALU ops against a behavioural load model.
// Honours MS_LOAD_BYPASS_EN for the ID bypass expectations.
module tb_mem_stage;
    localparam int EXC_W = 16;
    localparam logic [4:0] LD_W = 5'b10000, LD_H = 5'b01000, LD_HU = 5'b00100,
                           LD_B = 5'b00010, LD_BU = 5'b00001;

    logic             clk = 1'b0;
    logic             reset;
    logic             es_to_ms_valid;
    logic             ms_allowin;
    logic [31:0]      es_pc, es_result;
    logic             es_rf_we;
    logic [4:0]       es_rf_waddr;
    logic             es_res_from_mem, es_mem_req;
    logic [4:0]       es_ld_op;
    logic [EXC_W-1:0] es_except;
    logic             data_sram_data_ok;
    logic [31:0]      data_sram_rdata;
    logic             ws_allowin, except_flush;
    logic             ms_to_ws_valid;
    logic [31:0]      ms_pc, ms_final_result;
    logic             ms_rf_we;
    logic [4:0]       ms_rf_waddr;
    logic [EXC_W-1:0] ms_except;
    logic [38:0]      ms_rf_collect;

    int checks = 0;
    int errors = 0;

`ifdef MS_LOAD_BYPASS_EN
    localparam logic PEND_ON_OK = 1'b0;
`else
    localparam logic PEND_ON_OK = 1'b1;
`endif

    always #5 clk = ~clk;

    mem_stage #(.EXC_W(EXC_W)) dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_result(es_result), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
        .es_res_from_mem(es_res_from_mem), .es_mem_req(es_mem_req), .es_ld_op(es_ld_op),
        .es_except(es_except), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .except_flush(except_flush),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_final_result(ms_final_result),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_except(ms_except),
        .ms_rf_collect(ms_rf_collect)
    );

    // Reference: pick the addressed byte/halfword arithmetically and extend.
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned b, h;
        int v;
        b = (word >> (8 * addr[1:0])) % 256;
        h = (word >> (16 * addr[1])) % 65536;
        case (op)
            LD_W:    return word;
            LD_B:    begin v = int'(b); if (v > 127) v = v - 256; return 32'(v); end
            LD_BU:   return 32'(b);
            LD_H:    begin v = int'(h); if (v > 32767) v = v - 65536; return 32'(v); end
            LD_HU:   return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic we,
                         input logic [4:0] wa, input logic from_mem, input logic req,
                         input logic [4:0] op, input logic [EXC_W-1:0] exc);
        es_pc = pc; es_result = res; es_rf_we = we; es_rf_waddr = wa;
        es_res_from_mem = from_mem; es_mem_req = req; es_ld_op = op; es_except = exc;
        es_to_ms_valid = 1'b1;
        #1;
        checks++;
        if (ms_allowin !== 1'b1) begin errors++; $display("FAIL issue_allowin: got %b expected 1", ms_allowin); end
        step();
        es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; es_to_ms_valid = 0; data_sram_data_ok = 0; except_flush = 0;
        ws_allowin = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        checks++;
        if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin); end
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ms_to_ws_valid); end
        checks++;
        if ({ms_pc, ms_final_result, ms_except} !== '0) begin errors++; $display("FAIL reset_payload: got %h %h %h expected 0", ms_pc, ms_final_result, ms_except); end
        checks++;
        if (ms_rf_collect !== 39'd0 || ms_rf_we !== 1'b0 || ms_rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_collect: got %h expected 0", ms_rf_collect); end
        // a response with nothing outstanding is ignored
        data_sram_data_ok = 1'b1; data_sram_rdata = $urandom;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL idle_data_ok: got %b expected 0", ms_to_ws_valid); end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        $display("reset done");
    endtask

    task automatic test_alu();
        logic [31:0] r, pc;
        logic [4:0]  wa;
        for (int i = 0; i < 5; i++) begin
            r = (i == 0) ? 32'h1234_5678 : $urandom;
            pc = $urandom; wa = 5'($urandom_range(1, 31));
            issue(pc, r, 1'b1, wa, 1'b0, 1'b0, 5'd0, '0);
            checks++;
            if (ms_to_ws_valid !== 1'b1 || ms_final_result !== r) begin errors++; $display("FAIL alu_result: got %b/%h expected 1/%h", ms_to_ws_valid, ms_final_result, r); end
            checks++;
            if (ms_pc !== pc || ms_rf_we !== 1'b1 || ms_rf_waddr !== wa) begin errors++; $display("FAIL alu_payload: got %h/%b/%0d expected %h/1/%0d", ms_pc, ms_rf_we, ms_rf_waddr, pc, wa); end
            step();
            checks++;
            if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin errors++; $display("FAIL alu_occupancy: got valid %b allowin %b expected 0/1", ms_to_ws_valid, ms_allowin); end
            $display("alu pc=%h result=%h", pc, r);
        end
    endtask

    task automatic test_load_align();
        logic [4:0]  ops [3] = '{LD_B, LD_BU, LD_H};
        logic [1:0]  offs[3] = '{2'd3, 2'd3, 2'd2};
        logic [31:0] exps[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        logic [4:0]  op;
        logic [31:0] addr, d, exp;
        for (int i = 0; i < 11; i++) begin
            if (i < 3) begin
                op = ops[i]; addr = {$urandom, 2'b00} | 32'(offs[i]); d = 32'h80FF_0000; exp = exps[i];
            end else begin
                op = 5'd1 << $urandom_range(0, 4); addr = $urandom; d = $urandom;
                exp = ref_load(op, addr, d);
            end
            issue($urandom, addr, 1'b1, 5'd7, 1'b1, 1'b1, op, '0);
            checks++;
            if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL load_wait: got %b expected 0", ms_to_ws_valid); end
            data_sram_data_ok = 1'b1; data_sram_rdata = d;
            #1;
            checks++;
            if (ms_to_ws_valid !== 1'b1 || ms_final_result !== exp) begin errors++; $display("FAIL load_align: op %b addr %h rdata %h got %b/%h expected 1/%h", op, addr, d, ms_to_ws_valid, ms_final_result, exp); end
            step();
            data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
            #1;
            checks++;
            if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL load_leave: got %b expected 0", ms_to_ws_valid); end
            $display("load op=%b addr=%h rdata=%h result=%h", op, addr, d, exp);
        end
    endtask

    task automatic test_load_stall();
        logic [31:0] r;
        r = $urandom;
        issue(32'h40, 32'h1000, 1'b1, 5'd3, 1'b1, 1'b1, LD_W, '0);
        ws_allowin = 1'b0;
        repeat (3) step();
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stall_wait: got %b expected 0", ms_to_ws_valid); end
        data_sram_data_ok = 1'b1; data_sram_rdata = r;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin errors++; $display("FAIL stall_ok: got valid %b allowin %b expected 1/0", ms_to_ws_valid, ms_allowin); end
        step();
        data_sram_data_ok = 1'b0; data_sram_rdata = ~r;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ms_to_ws_valid !== 1'b1 || ms_final_result !== r || ms_rf_collect[38] !== 1'b0) begin errors++; $display("FAIL stall_hold: got %b/%h pend %b expected 1/%h pend 0", ms_to_ws_valid, ms_final_result, ms_rf_collect[38], r); end
            step();
        end
        ws_allowin = 1'b1;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== r) begin errors++; $display("FAIL stall_drain: got %b/%h expected 1/%h", ms_to_ws_valid, ms_final_result, r); end
        step();
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stall_leave: got %b expected 0", ms_to_ws_valid); end
        $display("stall load rdata=%h held and drained", r);
    endtask

    task automatic test_flush_discard();
        logic [31:0] a, b;
        a = $urandom; b = ~a;
        issue(32'h80, 32'h100, 1'b1, 5'd4, 1'b1, 1'b1, LD_W, '0);
        step();
        except_flush = 1'b1;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ms_to_ws_valid); end
        step();
        except_flush = 1'b0;
        #1;
        issue(32'h84, 32'h204, 1'b1, 5'd5, 1'b1, 1'b1, LD_W, '0);
        data_sram_data_ok = 1'b1; data_sram_rdata = a;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stale_drop: got %b expected 0", ms_to_ws_valid); end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stale_after: got %b expected 0", ms_to_ws_valid); end
        step();
        data_sram_data_ok = 1'b1; data_sram_rdata = b;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== b || ms_pc !== 32'h84) begin errors++; $display("FAIL fresh_load: got %b/%h pc %h expected 1/%h pc 84", ms_to_ws_valid, ms_final_result, ms_pc, b); end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fresh_leave: got %b expected 0", ms_to_ws_valid); end
        $display("flush: stale %h dropped, new load got %h", a, b);
    endtask

    task automatic test_except();
        issue(32'hC0, 32'h300, 1'b1, 5'd9, 1'b1, 1'b0, LD_W, 16'h8000);
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_except !== 16'h8000) begin errors++; $display("FAIL except_pass: got %b/%h expected 1/8000", ms_to_ws_valid, ms_except); end
        checks++;
        if (ms_rf_collect[38:32] !== {1'b0, 1'b1, 5'd9}) begin errors++; $display("FAIL except_collect: got %b expected 0_1_01001", ms_rf_collect[38:32]); end
        step();
        checks++;
        if (ms_except !== 16'h0 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL except_clear: got %h/%b expected 0/0", ms_except, ms_to_ws_valid); end
        $display("except 8000 passed without wait");
    endtask

    task automatic test_bypass();
        logic [31:0] addr, d, exp;
        for (int i = 0; i < 3; i++) begin
            addr = $urandom; d = $urandom;
            exp = ref_load(LD_H, addr, d);
            issue($urandom, addr, 1'b1, 5'd12, 1'b1, 1'b1, LD_H, '0);
            checks++;
            if (ms_rf_collect[38] !== 1'b1) begin errors++; $display("FAIL bypass_pending_wait: got %b expected 1", ms_rf_collect[38]); end
            data_sram_data_ok = 1'b1; data_sram_rdata = d;
            #1;
            checks++;
            if (ms_rf_collect[38] !== PEND_ON_OK) begin errors++; $display("FAIL bypass_pending_ok: got %b expected %b", ms_rf_collect[38], PEND_ON_OK); end
            checks++;
            if (ms_to_ws_valid !== 1'b1 || ms_final_result !== exp) begin errors++; $display("FAIL bypass_wb: got %b/%h expected 1/%h", ms_to_ws_valid, ms_final_result, exp); end
`ifdef MS_LOAD_BYPASS_EN
            checks++;
            if (ms_rf_collect[31:0] !== exp) begin errors++; $display("FAIL bypass_data: got %h expected %h", ms_rf_collect[31:0], exp); end
`endif
            step();
            data_sram_data_ok = 1'b0;
            #1;
            $display("bypass ld_h addr=%h rdata=%h result=%h", addr, d, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        es_pc = 0; es_result = 0; es_rf_we = 0; es_rf_waddr = 0; es_res_from_mem = 0;
        es_mem_req = 0; es_ld_op = 0; es_except = 0; data_sram_rdata = 0;
        test_reset();
        test_alu();
        test_load_align();
        test_load_stall();
        test_flush_discard();
        test_except();
        test_bypass();
        issue(32'hDEAD_BEE0, 32'h5555_AAAA, 1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 16'h0001);
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It accepts one instruction per handshake from EX, waits for the data-SRAM response of any memory request EX issued on its behalf, aligns and extends load data, and forwards result, exception vector and register-file write information to WB. It also publishes a bypass/stall bundle for ID and discards SRAM responses belonging to instructions flushed by an exception.

## Interface
Parameters:
- `EXC_W`, 16, width of the exception vector carried from EX.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `es_to_ms_valid`  in  1  EX holds a valid instruction for MS.
- `ms_allowin`  out  1  MS can accept an instruction this cycle.
- `es_pc`  in  32  instruction PC.
- `es_result`  in  32  EX result; for memory ops, the virtual address.
- `es_rf_we` / `es_rf_waddr`  in  1 / 5  register write enable / index.
- `es_res_from_mem`  in  1  instruction is a load.
- `es_mem_req`  in  1  EX issued an accepted SRAM request (addr_ok seen).
- `es_ld_op`  in  5  one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}.
- `es_except`  in  EXC_W  exception vector from EX.
- `data_sram_data_ok`  in  1  SRAM response strobe.
- `data_sram_rdata`  in  32  SRAM read data.
- `ws_allowin`  in  1  WB can accept.
- `except_flush`  in  1  pipeline flush from WB.
- `ms_to_ws_valid`  out  1  MS offers an instruction to WB.
- `ms_pc`  out  32  registered PC.
- `ms_final_result`  out  32  aligned load data or passed-through result.
- `ms_rf_we` / `ms_rf_waddr`  out  1 / 5  qualified by ms_valid.
- `ms_except`  out  EXC_W  exception vector, zero when not valid.
- `ms_rf_collect`  out  39  {ms_load_pending, ms_rf_we, ms_rf_waddr, ms_final_result} for ID bypass/stall.

## Operation
- Registers: `ms_valid`, payload regs, `data_buf[31:0]`, `data_buf_valid`, `discard_cnt[1:0]`.
- `ms_valid`: cleared by reset or except_flush; else loads es_to_ms_valid when ms_allowin.
- Payload captured when es_to_ms_valid & ms_allowin; cleared to 0 on reset.
- `ms_wait = ms_valid & ms_mem_req & ~data_buf_valid`.
- `ms_ready_go = ~ms_wait | (data_sram_data_ok & discard_cnt==0)`.
- `ms_allowin = ~ms_valid | ms_ready_go & ws_allowin`; `ms_to_ws_valid = ms_valid & ms_ready_go & ~except_flush`.
- Response capture: data_ok with discard_cnt==0 and ms_wait sets data_buf_valid, stores rdata; buf cleared when instruction leaves (ms_ready_go & ws_allowin) or on flush.
- Discard: on except_flush, if ms_wait & ~data_ok, discard_cnt increments (saturate at 3). Any data_ok while discard_cnt>0 decrements it and is dropped (does not complete any instruction).
- Load align, offset = ms_result[1:0], source = data_ok ? rdata : data_buf: ld_w word; ld_b/bu byte at offset*8, sign/zero-extended; ld_h/hu halfword at offset[1]*16, sign/zero-extended. Non-load: ms_final_result = ms_result.
- ms_except nonzero implies EX did not issue (ms_mem_req=0); no wait.
- `ms_load_pending = ms_valid & ms_res_from_mem & ~ms_ready_go`.

## Timing
- Reset: all outputs 0; ms_allowin=1; discard_cnt=0.
- Non-memory instruction: one cycle in MS when WB ready.
- Load: leaves in the data_ok cycle at earliest (zero added latency); if WB stalls, data held in data_buf until drain.
- Flush and data_ok same cycle: response consumed by the flushed instruction, counter unchanged.
- data_ok while ms_valid=0 and discard_cnt=0: ignored.

## Configuration
- `MS_LOAD_BYPASS_EN` defined: ms_rf_collect data and ms_load_pending reflect aligned rdata combinationally in the data_ok cycle.
- Undefined: bypass data comes only from data_buf; ms_load_pending stays 1 in the data_ok cycle, so ID sees load data one cycle later; WB path unchanged.

## Test plan
- ALU op, result 0x1234_5678, WB ready -> ms_to_ws_valid next cycle, ms_final_result=0x1234_5678, 1-cycle occupancy.
- ld_b, addr offset 3, rdata 0x80FF_0000 -> result 0xFFFF_FF80; ld_bu -> 0x0000_0080; ld_h offset 2 -> 0xFFFF_80FF.
- ld_w, data_ok 4 cycles late, ws_allowin low 2 more cycles -> data_buf holds rdata, exits when ws_allowin rises, value intact.
- Flush while load waits, data_ok 3 cycles later, new load accepted meanwhile -> stale response dropped, discard_cnt 1->0, new load gets its own rdata.
- ms_except=0x8000 on a load with ms_mem_req=0 -> no wait, passes to WB with exception vector unchanged.
- Bypass macro on vs off: data_ok cycle ms_load_pending 0 vs 1 with identical WB outputs.
